dram_addr_sequencer: RTL and testbench

- Sequences one DRAM bank whose multiplexed address lines are driven by a bank of 74F257 quad 2:1 tri-state muxes.
- Latches the requester's address into row/column halves feeding the mux I0/I1 inputs, and drives mux select S and output enable _OE.
- Generates _RAS/_CAS/_WE timing, arbitrates between a CPU port and a chipset DMA port, and inserts periodic CAS-before-RAS refresh.

---
 rtl/dram_addr_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_dram_addr_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_addr_sequencer.sv
// Single-bank DRAM sequencer driving 74F257 row/column address muxes,
// with DMA-over-CPU arbitration and CAS-before-RAS refresh.
module dram_addr_sequencer #(
    parameter int MA_W         = 9,
    parameter int T_RCD        = 2,
    parameter int T_CAS        = 2,
    parameter int T_RP         = 2,
    parameter int T_REF        = 3,
    parameter int REF_INTERVAL = 64
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CPU_REQ,
    input  logic [2*MA_W-1:0] CPU_ADDR,
    input  logic              CPU_WE,
    output logic              CPU_ACK,
    input  logic              DMA_REQ,
    input  logic [2*MA_W-1:0] DMA_ADDR,
    input  logic              DMA_WE,
    output logic              DMA_ACK,
    output logic [MA_W-1:0]   ROW_ADDR,
    output logic [MA_W-1:0]   COL_ADDR,
    output logic              MUX_S,
    output logic              _MUX_OE,
    output logic              _RAS,
    output logic              _CAS,
    output logic              _WE,
    output logic              REF_OVERRUN
);

    localparam int TMAX_A = (T_RCD > T_CAS) ? T_RCD : T_CAS;
    localparam int TMAX_B = (T_RP > T_REF) ? T_RP : T_REF;
    localparam int TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
    localparam int CW     = $clog2(TMAX + 1);
    localparam int RW     = $clog2(REF_INTERVAL);

    localparam logic [CW-1:0] RCD_LAST = CW'(T_RCD - 1);
    localparam logic [CW-1:0] CAS_LAST = CW'(T_CAS - 1);
    localparam logic [CW-1:0] CAS_ACK  = CW'(T_CAS - 2);
    localparam logic [CW-1:0] RP_LAST  = CW'(T_RP - 1);
    localparam logic [CW-1:0] REF_LAST = CW'(T_REF - 1);
    localparam logic [RW-1:0] INT_LAST = RW'(REF_INTERVAL - 1);

    typedef enum logic [2:0] {
        IDLE,
        RAS_SETUP,
        RAS_ACT,
        COL,
        CAS_ACT,
        PRECHARGE,
        REF_CAS,
        REF_RAS
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [RW-1:0] ref_cnt;
    logic          ref_pend;
    logic          lat_we;
    logic          gnt_dma;
    logic          ref_wrap;
    logic          ref_grant;

    assign ref_wrap  = (ref_cnt == INT_LAST);
    assign ref_grant = (state == IDLE) && ref_pend;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            cnt         <= '0;
            ref_cnt     <= '0;
            ref_pend    <= 1'b0;
            lat_we      <= 1'b0;
            gnt_dma     <= 1'b0;
            CPU_ACK     <= 1'b0;
            DMA_ACK     <= 1'b0;
            ROW_ADDR    <= '0;
            COL_ADDR    <= '0;
            MUX_S       <= 1'b0;
            _MUX_OE     <= 1'b1;
            _RAS        <= 1'b1;
            _CAS        <= 1'b1;
            _WE         <= 1'b1;
            REF_OVERRUN <= 1'b0;
        end else begin
            CPU_ACK <= 1'b0;
            DMA_ACK <= 1'b0;
            ref_cnt <= ref_wrap ? '0 : ref_cnt + 1'b1;

            // A wrap coinciding with a grant re-arms pending without overrun
            if (ref_wrap) begin
                ref_pend <= 1'b1;
                if (ref_pend && !ref_grant) begin
                    REF_OVERRUN <= 1'b1;
                end
            end else if (ref_grant) begin
                ref_pend <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (ref_pend) begin
                        state   <= REF_CAS;
                        _CAS    <= 1'b0;
                        _RAS    <= 1'b1;
                        _MUX_OE <= 1'b1;
                    end else if (DMA_REQ) begin
                        state    <= RAS_SETUP;
                        ROW_ADDR <= DMA_ADDR[2*MA_W-1:MA_W];
                        COL_ADDR <= DMA_ADDR[MA_W-1:0];
                        lat_we   <= DMA_WE;
                        gnt_dma  <= 1'b1;
                        MUX_S    <= 1'b0;
                        _MUX_OE  <= 1'b0;
                        _RAS     <= 1'b1;
                    end else if (CPU_REQ) begin
                        state    <= RAS_SETUP;
                        ROW_ADDR <= CPU_ADDR[2*MA_W-1:MA_W];
                        COL_ADDR <= CPU_ADDR[MA_W-1:0];
                        lat_we   <= CPU_WE;
                        gnt_dma  <= 1'b0;
                        MUX_S    <= 1'b0;
                        _MUX_OE  <= 1'b0;
                        _RAS     <= 1'b1;
                    end
                end
                RAS_SETUP: begin
                    state <= RAS_ACT;
                    cnt   <= '0;
                    _RAS  <= 1'b0;
                end
                RAS_ACT: begin
                    if (cnt == RCD_LAST) begin
                        state <= COL;
                        MUX_S <= 1'b1;
                        _WE   <= ~lat_we;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                COL: begin
                    state <= CAS_ACT;
                    cnt   <= '0;
                    _CAS  <= 1'b0;
                    if (CAS_LAST == '0) begin
                        if (gnt_dma) DMA_ACK <= 1'b1;
                        else         CPU_ACK <= 1'b1;
                    end
                end
                CAS_ACT: begin
                    if (cnt == CAS_LAST) begin
                        state   <= PRECHARGE;
                        cnt     <= '0;
                        _RAS    <= 1'b1;
                        _CAS    <= 1'b1;
                        _WE     <= 1'b1;
                        _MUX_OE <= 1'b1;
                        MUX_S   <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        // ACK is registered, so raise it entering the last cycle
                        if (cnt == CAS_ACK) begin
                            if (gnt_dma) DMA_ACK <= 1'b1;
                            else         CPU_ACK <= 1'b1;
                        end
                    end
                end
                PRECHARGE: begin
                    if (cnt == RP_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                REF_CAS: begin
                    state <= REF_RAS;
                    cnt   <= '0;
                    _RAS  <= 1'b0;
                end
                REF_RAS: begin
                    if (cnt == REF_LAST) begin
                        state <= PRECHARGE;
                        cnt   <= '0;
                        _RAS  <= 1'b1;
                        _CAS  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dram_addr_sequencer.sv
// Directed testbench for dram_addr_sequencer: access timing, arbitration,
// refresh, overrun and asynchronous reset.
module tb_dram_addr_sequencer;

    localparam logic [17:0] ADDR_A = 18'h2A5F3;
    localparam logic [17:0] ADDR_B = 18'h0ABCD;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [17:0] cpu_addr, dma_addr;
    logic        cpu_ack, dma_ack, mux_s, oe_n, ras_n, cas_n, we_n, ovr;
    logic [8:0]  row_addr, col_addr;

    logic        r_req, r_cack, r_dack, r_s, r_oe, r_ras, r_cas, r_we, r_ovr;
    logic [8:0]  r_row, r_col;
    logic        o_req, o_cack, o_dack, o_s, o_oe, o_ras, o_cas, o_we, o_ovr;
    logic [8:0]  o_row, o_col;

    dram_addr_sequencer u_dut (
        .CLK(clk), .RESET(rst),
        .CPU_REQ(cpu_req), .CPU_ADDR(cpu_addr), .CPU_WE(cpu_we), .CPU_ACK(cpu_ack),
        .DMA_REQ(dma_req), .DMA_ADDR(dma_addr), .DMA_WE(dma_we), .DMA_ACK(dma_ack),
        .ROW_ADDR(row_addr), .COL_ADDR(col_addr), .MUX_S(mux_s), ._MUX_OE(oe_n),
        ._RAS(ras_n), ._CAS(cas_n), ._WE(we_n), .REF_OVERRUN(ovr)
    );

    dram_addr_sequencer #(.REF_INTERVAL(16)) u_r16 (
        .CLK(clk), .RESET(rst),
        .CPU_REQ(1'b0), .CPU_ADDR(18'h0), .CPU_WE(1'b0), .CPU_ACK(r_cack),
        .DMA_REQ(r_req), .DMA_ADDR(ADDR_B), .DMA_WE(1'b0), .DMA_ACK(r_dack),
        .ROW_ADDR(r_row), .COL_ADDR(r_col), .MUX_S(r_s), ._MUX_OE(r_oe),
        ._RAS(r_ras), ._CAS(r_cas), ._WE(r_we), .REF_OVERRUN(r_ovr)
    );

    dram_addr_sequencer #(
        .T_RCD(12), .T_CAS(12), .T_RP(12), .REF_INTERVAL(16)
    ) u_ovr (
        .CLK(clk), .RESET(rst),
        .CPU_REQ(1'b0), .CPU_ADDR(18'h0), .CPU_WE(1'b0), .CPU_ACK(o_cack),
        .DMA_REQ(o_req), .DMA_ADDR(ADDR_A), .DMA_WE(1'b0), .DMA_ACK(o_dack),
        .ROW_ADDR(o_row), .COL_ADDR(o_col), .MUX_S(o_s), ._MUX_OE(o_oe),
        ._RAS(o_ras), ._CAS(o_cas), ._WE(o_we), .REF_OVERRUN(o_ovr)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic       t_ras[160], t_cas[160], t_we[160], t_oe[160];
    logic       t_s[160], t_cack[160], t_dack[160];
    logic [8:0] t_row[160];

    int c_ras, c_cas, c_we, c_oe, c_cack, c_dack, c_both;
    int f_ras, f_cas, f_we;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        cpu_req = 1'b0;
        dma_req = 1'b0;
        r_req   = 1'b0;
        o_req   = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Sample main DUT after each edge; drop a request once its ACK is seen
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            t_ras[i]  = ras_n;
            t_cas[i]  = cas_n;
            t_we[i]   = we_n;
            t_oe[i]   = oe_n;
            t_s[i]    = mux_s;
            t_cack[i] = cpu_ack;
            t_dack[i] = dma_ack;
            t_row[i]  = row_addr;
            if (cpu_ack) cpu_req = 1'b0;
            if (dma_ack) dma_req = 1'b0;
        end
    endtask

    task automatic tally(input int n);
        c_ras = 0; c_cas = 0; c_we = 0; c_oe = 0;
        c_cack = 0; c_dack = 0; c_both = 0;
        f_ras = -1; f_cas = -1; f_we = -1;
        for (int i = 0; i < n; i++) begin
            if (!t_ras[i]) begin
                c_ras++;
                if (f_ras < 0) f_ras = i;
            end
            if (!t_cas[i]) begin
                c_cas++;
                if (f_cas < 0) f_cas = i;
            end
            if (!t_we[i]) begin
                c_we++;
                if (f_we < 0) f_we = i;
            end
            if (!t_oe[i]) c_oe++;
            if (t_cack[i]) c_cack++;
            if (t_dack[i]) c_dack++;
            if (t_cack[i] && t_dack[i]) c_both++;
        end
    endtask

    initial begin
        int refs;
        int acks;
        rst = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0;
        r_req = 1'b0; o_req = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ras", ras_n, 1);
        chk("rst_cas", cas_n, 1);
        chk("rst_we", we_n, 1);
        chk("rst_oe", oe_n, 1);
        chk("rst_s", mux_s, 0);
        chk("rst_acks", {cpu_ack, dma_ack}, 0);
        chk("rst_row", row_addr, 0);
        chk("rst_col", col_addr, 0);
        chk("rst_ovr", ovr, 0);
        rst = 1'b0;

        // CPU read
        do_reset();
        cpu_req = 1'b1; cpu_addr = ADDR_A; cpu_we = 1'b0;
        run(12);
        tally(12);
        chk("rd_row", t_row[0], 32'(ADDR_A[17:9]));
        chk("rd_col", col_addr, 32'(ADDR_A[8:0]));
        chk("rd_s_row", t_s[2], 0);
        chk("rd_s_col", t_s[3], 1);
        chk("rd_we_lo", c_we, 0);
        chk("rd_ack_at5", t_cack[5], 1);
        chk("rd_ack_cnt", c_cack, 1);
        chk("rd_ras_lo", c_ras, 5);
        chk("rd_ras_first", f_ras, 1);
        chk("rd_cas_lo", c_cas, 2);
        chk("rd_cas_first", f_cas, 4);

        // CPU write
        do_reset();
        cpu_req = 1'b1; cpu_addr = ADDR_A; cpu_we = 1'b1;
        run(12);
        tally(12);
        chk("wr_we_lo", c_we, 3);
        chk("wr_we_first", f_we, 3);
        chk("wr_oe_lo", c_oe, 6);
        chk("wr_ack_at5", t_cack[5], 1);

        // Simultaneous CPU and DMA
        do_reset();
        cpu_req = 1'b1; cpu_addr = ADDR_A; cpu_we = 1'b0;
        dma_req = 1'b1; dma_addr = ADDR_B; dma_we = 1'b0;
        run(20);
        tally(20);
        chk("arb_dma_ack", t_dack[5], 1);
        chk("arb_cpu_ack", t_cack[14], 1);
        chk("arb_ack_cnt", {c_dack[7:0], c_cack[7:0]}, 16'h0101);
        chk("arb_both", c_both, 0);
        chk("arb_row_dma", t_row[0], 32'(ADDR_B[17:9]));
        chk("arb_row_cpu", t_row[9], 32'(ADDR_A[17:9]));

        // Idle refresh every 64 cycles
        do_reset();
        run(140);
        tally(140);
        chk("ref_cas_first", f_cas, 64);
        chk("ref_ras_at64", t_ras[64], 1);
        chk("ref_ras_first", f_ras, 65);
        chk("ref_ras_lo", c_ras, 6);
        chk("ref_cas_lo", c_cas, 8);
        chk("ref_oe_lo", c_oe, 0);
        chk("ref2_cas_127", t_cas[127], 1);
        chk("ref2_cas_128", t_cas[128], 0);
        chk("ref_ovr", ovr, 0);

        // DMA held with 16-cycle refresh interval
        do_reset();
        r_req = 1'b1;
        refs = 0;
        acks = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (!r_cas && r_ras) refs++;
            if (r_dack) acks++;
        end
        chk("r16_refs", (refs >= 11 && refs <= 12), 1);
        chk("r16_acks", (acks >= 10), 1);
        chk("r16_ovr", r_ovr, 0);

        // Long access spans two wraps
        do_reset();
        o_req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (i == 16) chk("ovr_after_wrap1", o_ovr, 0);
            if (i == 25) chk("ovr_ack", o_dack, 1);
            if (i == 30) chk("ovr_before_wrap2", o_ovr, 0);
            if (i == 31) chk("ovr_at_wrap2", o_ovr, 1);
            if (i == 39) chk("ovr_ref_cas", {o_cas, o_ras}, 2'b01);
        end
        chk("ovr_sticky", o_ovr, 1);
        do_reset();
        chk("ovr_cleared", o_ovr, 0);

        // Reset mid CAS_ACT
        do_reset();
        cpu_req = 1'b1; cpu_addr = ADDR_A; cpu_we = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_pre_cas", cas_n, 0);
        #3 rst = 1'b1;
        #1;
        chk("mid_ras", ras_n, 1);
        chk("mid_cas", cas_n, 1);
        chk("mid_oe", oe_n, 1);
        chk("mid_s", mux_s, 0);
        cpu_req = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_no_ack", cpu_ack, 0);
        rst = 1'b0;
        cpu_req = 1'b1;
        run(12);
        tally(12);
        chk("post_ack_at5", t_cack[5], 1);
        chk("post_ack_cnt", c_cack, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
